// File: rtl/obstacle_renderer_if.sv
// rtl/obstacle_renderer_if.sv - scan-position / obstacle-flag bundle between graphics top and obstacle renderer
interface obstacle_renderer_if #(
  parameter int CONV = 0
);
  logic [9:CONV] i_hpos;
  logic [9:CONV] i_vpos;
  logic          i_game_tick_60hz;
  logic [2:0]    i_speed;
  logic          i_spawn;
  logic          i_halt;
  logic          o_color_obstacle;
  logic [1:0]    o_active;
  logic          o_passed;
  logic          o_spawn_drop;

  // graphics top side: drives scan position and game control, consumes the flag
  modport master (
    output i_hpos, i_vpos, i_game_tick_60hz, i_speed, i_spawn, i_halt,
    input  o_color_obstacle, o_active, o_passed, o_spawn_drop
  );

  // renderer side
  modport slave (
    input  i_hpos, i_vpos, i_game_tick_60hz, i_speed, i_spawn, i_halt,
    output o_color_obstacle, o_active, o_passed, o_spawn_drop
  );
endinterface

// File: rtl/obstacle_renderer.sv
// rtl/obstacle_renderer.sv - two-slot scrolling obstacle store with per-pixel hit flag
module obstacle_renderer #(
  parameter int CONV     = 0,
  parameter int GROUND_Y = 400,
  parameter int OBS_W    = 16,
  parameter int OBS_H    = 32,
  parameter int SPAWN_X  = 640
) (
  input  logic              clk,
  input  logic              rst_n,
  obstacle_renderer_if.slave bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } slot_state_t;

  localparam logic signed [10:0] SPAWN_X11 = 11'(SPAWN_X);
  localparam logic signed [11:0] W12       = 12'(OBS_W);
  localparam logic signed [11:0] V_TOP     = 12'(GROUND_Y - OBS_H);
  localparam logic signed [11:0] V_BOT     = 12'(GROUND_Y);
  localparam logic signed [11:0] H_LIMIT   = 12'sd640;

  slot_state_t        state [2];
  logic signed [10:0] x     [2];
  logic               passed_q;
  logic               drop_q;

  logic signed [10:0] nx     [2];
  logic        [1:0]  retire;
  logic               move_en;
  logic               spawn_free;
  logic               spawn_sel;

  logic        [9:0]  h10;
  logic        [9:0]  v10;
  logic signed [11:0] h12;
  logic signed [11:0] v12;
  logic signed [11:0] xs     [2];
  logic        [1:0]  hit;

  // Candidate positions after a tick, and which slots fall fully off the left edge
  always_comb begin
    move_en = bus.i_game_tick_60hz && !bus.i_halt;
    retire  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      nx[i] = x[i] - $signed({8'b0, bus.i_speed});
      if (move_en && state[i] == S_ACTIVE &&
          ($signed({nx[i][10], nx[i]}) + W12 <= 12'sd0)) begin
        retire[i] = 1'b1;
      end
    end
  end

  // Spawn target is the lowest slot idle before this edge; retiring slots still count as busy
  always_comb begin
    spawn_free = (state[0] == S_IDLE) || (state[1] == S_IDLE);
    spawn_sel  = (state[0] == S_IDLE) ? 1'b0 : 1'b1;
  end

  // Per-slot FSM plus registered event pulses; halt freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= S_IDLE;
        x[i]     <= SPAWN_X11;
      end
      passed_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      passed_q <= 1'b0;
      drop_q   <= 1'b0;
      if (!bus.i_halt) begin
        for (int i = 0; i < 2; i++) begin
          case (state[i])
            S_ACTIVE: begin
              if (retire[i]) begin
                state[i] <= S_IDLE;
                x[i]     <= SPAWN_X11;
              end else if (move_en) begin
                x[i] <= nx[i];
              end
            end
            default: begin
              if (bus.i_spawn && spawn_free && spawn_sel == 1'(i)) begin
                state[i] <= S_ACTIVE;
                x[i]     <= SPAWN_X11;
              end
            end
          endcase
        end
        passed_q <= |retire;
        drop_q   <= bus.i_spawn && !spawn_free;
      end
    end
  end

  // Full-resolution scan position, zero-extended to signed 12 bits for the compares
  always_comb begin
    h10 = 10'(bus.i_hpos) << CONV;
    v10 = 10'(bus.i_vpos) << CONV;
    h12 = $signed({2'b00, h10});
    v12 = $signed({2'b00, v10});
  end

  // Pixel is inside an active obstacle box; off-screen columns never match
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      xs[i]  = $signed({x[i][10], x[i]});
      hit[i] = (state[i] == S_ACTIVE) &&
               (h12 >= xs[i]) && (h12 < xs[i] + W12) && (h12 < H_LIMIT) &&
               (v12 >= V_TOP) && (v12 < V_BOT);
    end
  end

  assign bus.o_color_obstacle = |hit;
  assign bus.o_active         = {state[1] == S_ACTIVE, state[0] == S_ACTIVE};
  assign bus.o_passed         = passed_q;
  assign bus.o_spawn_drop     = drop_q;

endmodule

// File: tb/tb_obstacle_renderer.sv
// tb/tb_obstacle_renderer.sv - self-checking bench for obstacle_renderer (CONV=0 and CONV=1 instances)
module tb_obstacle_renderer;

  localparam int OBS_W   = 16;
  localparam int SPAWN_X = 640;
  localparam int V_TOP   = 368;
  localparam int V_BOT   = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spawn = 1'b0;
  logic       tick = 1'b0;
  logic       halt = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [9:0] hpos0 = 10'd0;
  logic [9:0] vpos0 = 10'd0;
  logic [9:1] hpos1 = 9'd0;
  logic [9:1] vpos1 = 9'd0;

  int checks = 0;
  int errors = 0;

  bit m_act [2];
  int m_x   [2];

  obstacle_renderer_if #(.CONV(0)) if0 ();
  obstacle_renderer_if #(.CONV(1)) if1 ();

  assign if0.i_hpos = hpos0;
  assign if0.i_vpos = vpos0;
  assign if0.i_game_tick_60hz = tick;
  assign if0.i_speed = speed;
  assign if0.i_spawn = spawn;
  assign if0.i_halt = halt;
  assign if1.i_hpos = hpos1;
  assign if1.i_vpos = vpos1;
  assign if1.i_game_tick_60hz = tick;
  assign if1.i_speed = speed;
  assign if1.i_spawn = spawn;
  assign if1.i_halt = halt;

  obstacle_renderer #(.CONV(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  obstacle_renderer #(.CONV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  typedef struct {
    int    h;
    int    v;
    bit    exp;
    string name;
  } pix_vec_t;

  pix_vec_t pv [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit mflag(input int h, input int v);
    bit f = 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_act[i] && h >= m_x[i] && h < m_x[i] + OBS_W && h < 640 && v >= V_TOP && v < V_BOT)
        f = 1'b1;
    return f;
  endfunction

  function automatic int mact();
    return {30'd0, m_act[1], m_act[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = SPAWN_X;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spawn = 1'b0;
    tick = 1'b0;
    halt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Apply one clock of control inputs, advance the model, compare outputs after the edge
  task automatic cycle(input bit sp, input bit tk, input int spd, input bit hl);
    bit ep = 1'b0;
    bit ed = 1'b0;
    bit found = 1'b0;
    bit was_act [2];
    int nx;
    was_act = m_act;
    if (!hl) begin
      if (tk) begin
        for (int i = 0; i < 2; i++) begin
          if (m_act[i]) begin
            nx = m_x[i] - spd;
            if (nx + OBS_W <= 0) begin
              m_act[i] = 1'b0;
              m_x[i]   = SPAWN_X;
              ep       = 1'b1;
            end else begin
              m_x[i] = nx;
            end
          end
        end
      end
      if (sp) begin
        for (int i = 0; i < 2; i++) begin
          if (!found && !was_act[i]) begin
            m_act[i] = 1'b1;
            m_x[i]   = SPAWN_X;
            found    = 1'b1;
          end
        end
        if (!found) ed = 1'b1;
      end
    end
    spawn = sp;
    tick  = tk;
    speed = 3'(spd);
    halt  = hl;
    @(posedge clk);
    #1;
    spawn = 1'b0;
    tick  = 1'b0;
    chk("active0", int'(if0.o_active), mact());
    chk("active1", int'(if1.o_active), mact());
    chk("passed", int'(if0.o_passed), int'(ep));
    chk("spawn_drop", int'(if0.o_spawn_drop), int'(ed));
  endtask

  // Drive a full-res pixel on both instances and compare the flag
  task automatic probe(input int h, input int v, input bit exp, input string name);
    logic [9:0] hv;
    logic [9:0] vv;
    hv = 10'(h);
    vv = 10'(v);
    hpos0 = hv;
    vpos0 = vv;
    hpos1 = hv[9:1];
    vpos1 = vv[9:1];
    #1;
    chk(name, int'(if0.o_color_obstacle), int'(exp));
    if (hv[0] == 1'b0 && vv[0] == 1'b0)
      chk({name, "_conv1"}, int'(if1.o_color_obstacle), int'(exp));
  endtask

  initial begin
    int cnt;
    int h;
    int v;
    bit rhalt;

    pv[0] = '{600, 368, 1'b1, "pix_top_left"};
    pv[1] = '{615, 399, 1'b1, "pix_bot_right"};
    pv[2] = '{599, 380, 1'b0, "pix_left_out"};
    pv[3] = '{616, 380, 1'b0, "pix_right_out"};
    pv[4] = '{600, 367, 1'b0, "pix_above"};
    pv[5] = '{600, 400, 1'b0, "pix_ground"};

    model_reset();
    hpos0 = 10'd640;
    vpos0 = 10'd380;
    #2;
    chk("rst_active", int'(if0.o_active), 0);
    chk("rst_passed", int'(if0.o_passed), 0);
    chk("rst_drop", int'(if0.o_spawn_drop), 0);
    chk("rst_flag", int'(if0.o_color_obstacle), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // spawn fill and overflow
    cycle(1, 0, 0, 0);
    chk("spawn1_const", int'(if0.o_active), 1);
    probe(640, 380, 1'b0, "spawn_x_offscreen");
    cycle(1, 0, 0, 0);
    chk("spawn2_const", int'(if0.o_active), 3);
    cycle(1, 0, 0, 0);
    chk("spawn3_drop_const", int'(if0.o_spawn_drop), 1);
    cycle(0, 0, 0, 0);
    chk("drop_one_cycle", int'(if0.o_spawn_drop), 0);

    // scroll to x=600 and check the box edges
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 4, 0);
    for (int i = 0; i < 6; i++) probe(pv[i].h, pv[i].v, pv[i].exp, pv[i].name);
    hpos1 = 9'd300;
    vpos1 = 9'd190;
    #1 chk("conv1_300_190", int'(if1.o_color_obstacle), 1);

    // scroll to x=-12 then retire
    for (int i = 0; i < 153; i++) cycle(0, 1, 4, 0);
    probe(3, 380, 1'b1, "neg_x_visible");
    probe(4, 380, 1'b0, "neg_x_right_out");
    cycle(0, 1, 4, 0);
    chk("retire_passed_const", int'(if0.o_passed), 1);
    chk("retire_idle_const", int'(if0.o_active), 0);
    cycle(0, 0, 0, 0);
    chk("passed_one_cycle", int'(if0.o_passed), 0);

    // both slots retiring together give one pulse
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 200 && m_act[0]; i++) begin
      cycle(0, 1, 7, 0);
      if (if0.o_passed) cnt++;
    end
    cycle(0, 0, 0, 0);
    if (if0.o_passed) cnt++;
    chk("dual_retire_pulses", cnt, 1);
    chk("dual_retire_idle", int'(if0.o_active), 0);

    // spawn and tick in the same cycle
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 108; i++) cycle(0, 1, 5, 0);
    cycle(1, 1, 5, 0);
    chk("simul_active", int'(if0.o_active), 3);
    probe(95, 380, 1'b1, "simul_x95_in");
    probe(94, 380, 1'b0, "simul_x95_left");
    probe(110, 380, 1'b1, "simul_x95_right_in");
    probe(111, 380, 1'b0, "simul_x95_right_out");

    // halt freezes state and pulses, flag still rendered
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 4, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 4, 1);
    cycle(1, 0, 4, 1);
    chk("halt_no_spawn", int'(if0.o_active), 1);
    probe(620, 380, 1'b1, "halt_render");
    probe(619, 380, 1'b0, "halt_frozen_x");
    cycle(0, 1, 4, 0);
    probe(619, 380, 1'b1, "halt_release_moves");
    probe(632, 380, 1'b0, "halt_release_right");

    // randomized traffic against the model
    do_reset();
    rhalt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) rhalt = ~rhalt;
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), rhalt);
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          h = m_x[i] + int'($urandom_range(0, 17)) - 1;
          if (h < 0) h = 0;
          v = int'($urandom_range(360, 405));
          probe(h, v, mflag(h, v), "rand_edge");
        end
      end
      h = int'($urandom_range(0, 1023));
      v = int'($urandom_range(0, 1023));
      probe(h, v, mflag(h, v), "rand_pix");
    end

    // asynchronous reset mid-frame
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 4, 0);
    probe(600, 380, 1'b1, "pre_async_flag");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_flag0", int'(if0.o_color_obstacle), 0);
    chk("async_flag1", int'(if1.o_color_obstacle), 0);
    chk("async_active", int'(if0.o_active), 0);
    chk("async_passed", int'(if0.o_passed), 0);
    chk("async_drop", int'(if0.o_spawn_drop), 0);
    #5 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_renderer.md
# obstacle_renderer

Pixel-query responder for the VGA pipeline. It consumes the scan position (`hpos`/`vpos`) and frame tick produced by the graphics top, and returns the `color_obstacle` flag that the graphics top registers, ORs into pixel colour and uses for collision. It owns two obstacle slots, and scrolls them left once per frame.

## Interface
Parameters:
- `CONV`, 0: position LSBs dropped on `i_hpos`/`i_vpos`; full-resolution coordinate = input << CONV.
- `GROUND_Y`, 400: full-res row just below obstacle bottom edge.
- `OBS_W`, 16: obstacle width, full-res pixels (1..64).
- `OBS_H`, 32: obstacle height, full-res pixels (1..GROUND_Y).
- `SPAWN_X`, 640: x loaded into a slot on spawn (left edge, full-res).

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_hpos` in [9:CONV]: current scan column.
- `i_vpos` in [9:CONV]: current scan row.
- `i_game_tick_60hz` in 1: one-cycle pulse at hpos=vpos=0.
- `i_speed` in 3: pixels moved per tick (0..7).
- `i_spawn` in 1: one-cycle spawn request.
- `i_halt` in 1: level; freezes all slot state.
- `o_color_obstacle` out 1: current pixel lies inside an active obstacle.
- `o_active` out 2: per-slot active flags.
- `o_passed` out 1: one-cycle pulse when any slot retires.
- `o_spawn_drop` out 1: one-cycle pulse when a spawn is rejected.

## Operation
- Slot state: `active` bit plus 11-bit signed `x` (left edge, full-res). Per-slot FSM: IDLE -> ACTIVE on accepted spawn; ACTIVE -> IDLE on retire.
- Spawn:
  - `i_spawn` with `i_halt`=0 loads the lowest-index IDLE slot with x=SPAWN_X and active=1.
  - If no slot is IDLE, `o_spawn_drop` pulses and state is unchanged.
  - `i_spawn` while halted is ignored, with no drop pulse.
- Move: on `i_game_tick_60hz` with `i_halt`=0, each ACTIVE slot computes nx = x - i_speed in 11-bit signed arithmetic.
  - If nx + OBS_W <= 0, the slot retires: active=0, x=SPAWN_X.
  - Otherwise x = nx.
- `o_passed` pulses once in any cycle where one or more slots retire. Two simultaneous retirements give a single pulse.
- Pixel flag (combinational from registered slot state and current position, so the consumer's register aligns it with its own pipeline):
  - Full-res position: h = i_hpos<<CONV, v = i_vpos<<CONV, both zero-extended to 11 bits signed.
  - `o_color_obstacle` = OR over ACTIVE slots of (x <= h < x+OBS_W) and (GROUND_Y-OBS_H <= v < GROUND_Y).
  - Portions with x < 0 or x >= 640 are simply never matched.
- Simultaneous events:
  - Spawn and tick in the same cycle: the newly loaded slot gets SPAWN_X, not decremented. Other slots move normally.
  - A slot retiring in the same cycle as a spawn still counts as busy, so the spawn takes the other slot or is dropped.
  - `i_speed`=0: ticks cause no movement and no retire.
- `i_halt`=1 freezes `x` and `active`. `o_color_obstacle` keeps rendering from the frozen state. `o_passed`/`o_spawn_drop` stay 0.

## Timing
- Reset (`rst_n`=0, asynchronous): both slots IDLE with x=SPAWN_X. `o_active`=0, `o_passed`=0, `o_spawn_drop`=0, `o_color_obstacle`=0.
- Reset release mid-frame is legal; the first movement happens on the next tick.
- Spawn/move/retire take effect at the next rising edge. `o_active` reflects the new state one cycle after the request/tick.
- `o_passed` and `o_spawn_drop` are registered, asserted for exactly the cycle after the triggering edge.
- `o_color_obstacle` has zero-cycle latency from `i_hpos`/`i_vpos`. Movement happens only at hpos=vpos=0, so a frame never tears.
- Spawn asserted for multiple consecutive cycles is treated as multiple requests (one per cycle).

## Test plan
- Reset then spawn: `i_spawn` pulse -> `o_active`=2'b01 next cycle, slot0 x=640. Second spawn -> `o_active`=2'b11. Third spawn -> `o_spawn_drop`=1 for one cycle, `o_active` unchanged.
- Scroll: spawn, `i_speed`=4, 10 ticks -> x=600. At that point the flag is 1 at (h=600,v=368) and (615,399), and 0 at (599,380), (616,380), (600,367), (600,400).
- Retire: slot at x=-12, speed 4, tick -> slot IDLE, `o_passed` one cycle. With both slots retiring on the same tick -> single `o_passed` pulse.
- Simultaneous: slot0 active at x=100, speed 5, spawn and tick same cycle -> slot0 x=95, slot1 x=640.
- Halt: `i_halt`=1, 5 ticks plus a spawn -> x unchanged, no new slot, no pulses, flag still rendered. Release halt -> movement resumes next tick.
- CONV=1: `i_hpos`=300, `i_vpos`=190 with slot at x=600 -> flag=1. Assert `rst_n`=0 mid-frame -> all outputs 0 immediately, without waiting for a clock edge.
